// File: rtl/cfg_pkg.sv
// cfg_pkg: definitions shared by the configuration bitstream loader.
//   state_e        loader frame-parser states
//   SYNC_BYTE_DEF  default frame start marker
//   CRC_POLY       CRC-8 generator polynomial (x^8 + x^2 + x + 1)
package cfg_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN_H,
        ST_LEN_L,
        ST_DATA,
        ST_CRC
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam logic [7:0] CRC_POLY      = 8'h07;

endpackage

// File: rtl/crc8_byte.sv
// crc8_byte: combinational CRC-8 update for one byte, MSB first.
//   crc_i   running CRC before the byte
//   byte_i  byte being absorbed
//   crc_o   running CRC after the byte
module crc8_byte
    import cfg_pkg::*;
(
    input  logic [7:0] crc_i,
    input  logic [7:0] byte_i,
    output logic [7:0] crc_o
);

    logic [7:0] c;

    // Folding the whole byte into the register first and then shifting eight
    // times is equivalent to feeding the bits in one at a time, MSB first.
    always_comb begin
        c = crc_i ^ byte_i;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[7]) c = (c << 1) ^ CRC_POLY;
            else      c = c << 1;
        end
        crc_o = c;
    end

endmodule

// File: rtl/cfg_loader.sv
// cfg_loader: parses framed configuration bitstreams and streams the payload
// into a nibble-wide configuration memory.
// Frame: SYNC, ADDR_H, ADDR_L, LEN_H, LEN_L, LEN payload bytes, CRC-8.
// Each payload byte becomes two nibble writes (low nibble first) at
// consecutive word addresses; the address wraps modulo 2**ADDR_W.
//   CLK        clock, posedge
//   RST_N      asynchronous active-low reset
//   DIN        bitstream byte
//   DIN_VALID  DIN holds a valid byte
//   DIN_READY  loader accepts DIN this cycle
//   WE         config-memory write strobe
//   WADDR      write word address
//   WDATA      write nibble
//   DONE       sticky: last frame passed its CRC
//   ERROR      sticky: last frame failed its CRC
// ADDR_W must lie in 9..16 (high address byte supplies bits [ADDR_W-1:8]).
module cfg_loader
    import cfg_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int unsigned ADDR_W    = 14
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [7:0]        DIN,
    input  logic              DIN_VALID,
    output logic              DIN_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [3:0]        WDATA,
    output logic              DONE,
    output logic              ERROR
);

    state_e            state_q;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [3:0]        wdata_q;
    logic              done_q;
    logic              err_q;
    logic [7:0]        crc_q;
    logic [7:0]        crc_d;
    logic [15:0]       cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_hi_d;
    logic              hi_pend_q;
    logic [3:0]        hi_nib_q;

    crc8_byte u_crc (
        .crc_i  (crc_q),
        .byte_i (DIN),
        .crc_o  (crc_d)
    );

    // High address beat replaces bits [ADDR_W-1:8]; surplus DIN bits dropped.
    always_comb begin
        addr_hi_d             = addr_q;
        addr_hi_d[ADDR_W-1:8] = DIN[ADDR_W-9:0];
    end

    // The cycle carrying the low-nibble write is the only one that refuses input.
    assign DIN_READY = ~hi_pend_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_HUNT;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            crc_q     <= '0;
            cnt_q     <= '0;
            addr_q    <= '0;
            hi_pend_q <= 1'b0;
            hi_nib_q  <= '0;
        end else begin
            we_q <= 1'b0;
            if (hi_pend_q) begin
                // Second write of a payload byte; independent of DIN_VALID
                // because the byte was already accepted.
                we_q      <= 1'b1;
                waddr_q   <= addr_q;
                wdata_q   <= hi_nib_q;
                addr_q    <= addr_q + ADDR_W'(1);
                hi_pend_q <= 1'b0;
                if (cnt_q == 16'd0) state_q <= ST_CRC;
            end else if (DIN_VALID) begin
                unique case (state_q)
                    ST_HUNT: begin
                        if (DIN == SYNC_BYTE) begin
                            done_q  <= 1'b0;
                            err_q   <= 1'b0;
                            crc_q   <= '0;
                            state_q <= ST_ADDR_H;
                        end
                    end
                    ST_ADDR_H: begin
                        addr_q  <= addr_hi_d;
                        crc_q   <= crc_d;
                        state_q <= ST_ADDR_L;
                    end
                    ST_ADDR_L: begin
                        addr_q[7:0] <= DIN;
                        crc_q       <= crc_d;
                        state_q     <= ST_LEN_H;
                    end
                    ST_LEN_H: begin
                        cnt_q[15:8] <= DIN;
                        crc_q       <= crc_d;
                        state_q     <= ST_LEN_L;
                    end
                    ST_LEN_L: begin
                        cnt_q[7:0] <= DIN;
                        crc_q      <= crc_d;
                        state_q    <= ({cnt_q[15:8], DIN} == 16'd0) ? ST_CRC : ST_DATA;
                    end
                    ST_DATA: begin
                        we_q      <= 1'b1;
                        waddr_q   <= addr_q;
                        wdata_q   <= DIN[3:0];
                        hi_nib_q  <= DIN[7:4];
                        addr_q    <= addr_q + ADDR_W'(1);
                        cnt_q     <= cnt_q - 16'd1;
                        crc_q     <= crc_d;
                        hi_pend_q <= 1'b1;
                    end
                    ST_CRC: begin
                        if (DIN == crc_q) done_q <= 1'b1;
                        else              err_q  <= 1'b1;
                        state_q <= ST_HUNT;
                    end
                    default: state_q <= ST_HUNT;
                endcase
            end
        end
    end

    assign WE    = we_q;
    assign WADDR = waddr_q;
    assign WDATA = wdata_q;
    assign DONE  = done_q;
    assign ERROR = err_q;

endmodule

// File: tb/tb_cfg_loader.sv
// tb_cfg_loader: randomized self-checking bench for cfg_loader.
// Frames are built as byte lists; expected writes, CRC and status come from
// a plain arithmetic model of the frame format.
module tb_cfg_loader;

    localparam int unsigned AW   = 14;
    localparam int unsigned MASK = (1 << AW) - 1;

    logic          CLK;
    logic          RST_N;
    logic [7:0]    DIN;
    logic          DIN_VALID;
    logic          DIN_READY;
    logic          WE;
    logic [AW-1:0] WADDR;
    logic [3:0]    WDATA;
    logic          DONE;
    logic          ERROR;

    cfg_loader #(
        .SYNC_BYTE (8'hA5),
        .ADDR_W    (AW)
    ) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .DIN       (DIN),
        .DIN_VALID (DIN_VALID),
        .DIN_READY (DIN_READY),
        .WE        (WE),
        .WADDR     (WADDR),
        .WDATA     (WDATA),
        .DONE      (DONE),
        .ERROR     (ERROR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int unsigned n_checks  = 0;
    int unsigned n_errors  = 0;
    int unsigned ready_err = 0;
    int unsigned got_q[$];
    logic [7:0]  payload_q[$];
    logic [7:0]  junk_q[$];
    bit          in_payload    = 1'b0;
    bit          last_pay_beat = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed writes, packed as {addr, nibble}.
    always @(negedge CLK) if (WE === 1'b1) got_q.push_back((int'(WADDR) << 4) | int'(WDATA));

    // Ready must drop exactly in the cycle after each accepted payload byte.
    always @(posedge CLK) last_pay_beat <= RST_N && DIN_VALID && DIN_READY && in_payload;
    always @(negedge CLK) if (RST_N && (DIN_READY !== !last_pay_beat)) ready_err++;

    function automatic logic [7:0] crc8_model(input logic [7:0] q[$]);
        logic [7:0] c = 8'h00;
        foreach (q[k]) begin
            for (int b = 7; b >= 0; b--) begin
                logic fb = c[7] ^ q[k][b];
                c = c << 1;
                if (fb) c = c ^ 8'h07;
            end
        end
        return c;
    endfunction

    // Called and returns at a negedge; the beat happens on the posedge between.
    task automatic send_byte(input logic [7:0] b, input int unsigned gap_max);
        int unsigned gaps = (gap_max == 0) ? 0 : $urandom_range(gap_max, 0);
        int unsigned guard = 0;
        DIN_VALID = 1'b0;
        repeat (gaps) @(negedge CLK);
        DIN       = b;
        DIN_VALID = 1'b1;
        while (!DIN_READY && guard < 8) begin
            @(negedge CLK);
            guard++;
        end
        if (!DIN_READY) check_val("ready_timeout", 32'd0, 32'd1);
        @(negedge CLK);
        DIN_VALID = 1'b0;
    endtask

    task automatic run_frame(input string name, input int unsigned raw_addr,
                             input bit corrupt, input int unsigned gap_max);
        logic [7:0]  body[$];
        logic [7:0]  crc;
        int unsigned len = payload_q.size();
        int unsigned exp_q[$];
        int unsigned a;

        body.push_back(8'((raw_addr >> 8) & 8'hFF));
        body.push_back(8'(raw_addr & 8'hFF));
        body.push_back(8'((len >> 8) & 8'hFF));
        body.push_back(8'(len & 8'hFF));
        foreach (payload_q[i]) body.push_back(payload_q[i]);
        crc = crc8_model(body);
        if (corrupt) crc = ~crc;

        for (int unsigned i = 0; i < len; i++) begin
            a = (raw_addr + 2 * i) & MASK;
            exp_q.push_back((a << 4) | (payload_q[i] & 4'hF));
            exp_q.push_back((((a + 1) & MASK) << 4) | (payload_q[i] >> 4));
        end

        got_q.delete();
        ready_err = 0;
        foreach (junk_q[i]) send_byte(junk_q[i], gap_max);
        send_byte(8'hA5, gap_max);
        for (int unsigned i = 0; i < 4; i++) send_byte(body[i], gap_max);
        in_payload = 1'b1;
        foreach (payload_q[i]) send_byte(payload_q[i], gap_max);
        in_payload = 1'b0;
        send_byte(crc, gap_max);
        repeat (3) @(negedge CLK);

        check_val({name, "_nwr"}, got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) check_val({name, "_wr"}, got_q[i], exp_q[i]);
        check_val({name, "_done"}, DONE, !corrupt);
        check_val({name, "_error"}, ERROR, corrupt);
        check_val({name, "_ready"}, ready_err, 0);
    endtask

    initial begin
        int unsigned v;
        RST_N     = 1'b0;
        DIN       = 8'h00;
        DIN_VALID = 1'b0;
        repeat (2) @(negedge CLK);
        check_val("rst_we", WE, 0);
        check_val("rst_waddr", WADDR, 0);
        check_val("rst_wdata", WDATA, 0);
        check_val("rst_done", DONE, 0);
        check_val("rst_error", ERROR, 0);
        RST_N = 1'b1;
        @(negedge CLK);
        check_val("rst_ready", DIN_READY, 1);

        // Single byte, good and inverted CRC.
        junk_q.delete();
        payload_q = '{8'h3C};
        run_frame("single_ok", 32'h0010, 1'b0, 0);
        run_frame("single_bad", 32'h0010, 1'b1, 0);

        // Address wrap, gapless then with gaps.
        payload_q = '{8'h12, 8'h34};
        run_frame("wrap", 32'h3FFF, 1'b0, 0);
        run_frame("wrap_gaps", 32'h3FFF, 1'b0, 3);

        // Leading junk and zero-length payload.
        junk_q    = '{8'h00, 8'hFF};
        payload_q.delete();
        run_frame("len0", 32'h0000, 1'b0, 0);

        // Upper high-address bits beyond ADDR_W must be ignored.
        junk_q.delete();
        payload_q = '{8'h9E};
        run_frame("addr_hi_ign", 32'hC123, 1'b0, 1);

        for (int unsigned f = 0; f < 12; f++) begin
            junk_q.delete();
            payload_q.delete();
            repeat ($urandom_range(2, 0)) begin
                v = $urandom_range(255, 0);
                junk_q.push_back((v == 8'hA5) ? 8'h5A : 8'(v));
            end
            repeat ($urandom_range(5, 0)) payload_q.push_back(8'($urandom_range(255, 0)));
            run_frame("rand", $urandom_range(16'hFFFF, 0), ($urandom_range(3, 0) == 0),
                      $urandom_range(3, 0));
        end

        // Reset during the cycle carrying the first nibble of a data beat.
        got_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h03, 0);
        in_payload = 1'b1;
        send_byte(8'h7B, 0);
        in_payload = 1'b0;
        #1 RST_N = 1'b0;
        #1;
        check_val("midrst_we", WE, 0);
        check_val("midrst_waddr", WADDR, 0);
        check_val("midrst_wdata", WDATA, 0);
        check_val("midrst_done", DONE, 0);
        check_val("midrst_error", ERROR, 0);
        check_val("midrst_ready", DIN_READY, 1);
        @(negedge CLK);
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);
        check_val("midrst_nwr", got_q.size(), 1);
        if (got_q.size() > 0) check_val("midrst_wr0", got_q[0], (32'h100 << 4) | 32'hB);

        payload_q = '{8'hA1, 8'h5F};
        run_frame("after_rst", 32'h0200, 1'b0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
